adder_tree_operand_loader: RTL
==============================

Name: adder_tree_operand_loader

Overview:
- Serial-to-parallel operand collector that sits directly upstream of the 5-input, 32-bit binary adder tree.
- Accepts operand words one per beat on a valid/ready stream and assembles a set of five operands.
- Presents the set in parallel on op_a..op_e with a valid/ready handshake to the consumer that drives the tree.
- Supports early set termination, with zero-fill of unused slots, and a synchronous flush.

Parameters:
WIDTH, 32, operand width in bits (must match adder tree width)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  operand word
in_valid  input  1  in_data valid
in_last  input  1  qualifies in_data as final word of the current set
in_ready  output  1  loader can accept a word this cycle
flush  input  1  synchronous clear of the partial or held set
op_a, op_b, op_c, op_d, op_e  output  WIDTH each  assembled operands (slot 0..4)
ops_valid  output  1  op_a..op_e hold a complete set
ops_ready  input  1  consumer accepts the set
fill_cnt  output  3  number of slots written in the current set (0..5)
chk_sum  output  WIDTH  reference sum; see Optional Feature

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low (rst_n). All state changes occur on the rising edge of clk.
- Reset: state=FILL, fill_cnt=0, op_a..op_e=0, ops_valid=0, chk_sum=0. in_ready=1 in the first cycle after reset deasserts.
- Two states, FILL and HOLD.
- FILL behaviour:
  - in_ready=1, ops_valid=0.
  - An input beat is accepted when in_valid & in_ready. The accepted word is written to slot[fill_cnt] and fill_cnt increments.
  - Transition to HOLD on the accepted beat when fill_cnt==4, or when in_last=1.
  - On in_last with fill_cnt<4, slots fill_cnt+1..4 are written with 0 on the same edge. fill_cnt becomes 5 in both cases.
  - in_last on the 5th word is legal and redundant.
- HOLD behaviour:
  - in_ready=0, ops_valid=1. op_a..op_e are stable until the handshake completes.
  - ops_valid & ops_ready completes the transfer: next state FILL, fill_cnt=0, all slots cleared to 0, ops_valid=0.
  - There is no same-cycle refill. The first word of the next set is accepted one cycle after the handshake.
- Latency: ops_valid rises 1 cycle after the accepting edge of the final word. Sustained throughput is one set per 6 cycles (5 beats plus 1 handshake cycle, ops_ready held high).
- Output regs: ops_valid and op_a..op_e are registered outputs with no combinational path from inputs. in_ready is decoded from state only and must not depend on in_valid.
- flush:
  - Highest priority after reset. On any edge with flush=1: state=FILL, fill_cnt=0, slots=0, ops_valid=0, chk_sum=0.
  - A beat presented with flush=1 is discarded, even though in_ready=1.
  - flush in HOLD with ops_ready=1 on the same cycle: the flush wins and the set is not counted as delivered (consumer must treat it as void).
- Reset mid-set: all partial contents are lost. No recovery of partial sets.
- Arithmetic: no width conversion; words are stored verbatim.
- Protocol violation: in_valid while in_ready=0 is ignored (no capture, no error flag).

Optional Feature:
- Macro: ADDER_TREE_LOADER_CHKSUM_EN.
- When defined:
  - chk_sum is a running accumulator, cleared at the start of each set.
  - It adds every accepted word (modulo 2^WIDTH; zero-filled slots add 0).
  - It is valid and stable while ops_valid=1, so the bench or downstream logic can compare it against the adder tree output.
  - Cleared on the handshake, on flush and on reset.
- When not defined: chk_sum is tied to 0 and no accumulator logic is synthesised. All other behaviour is identical.

Test Plan:
- Full set: reset, send 1,2,3,4,5 back-to-back (ops_ready=0) -> ops_valid=1 one cycle after 5th beat; op_a..op_e=1,2,3,4,5; in_ready=0; fill_cnt=5; chk_sum=15 (with CHKSUM_EN).
- Early last: send 0x10, 0x20 with in_last on 0x20 -> op_a=0x10, op_b=0x20, op_c..op_e=0, ops_valid=1, chk_sum=0x30.
- Backpressure: hold ops_ready=0 for 10 cycles after a complete set while driving in_valid=1 data 0xDEAD -> outputs unchanged, no capture. Raise ops_ready -> next cycle ops_valid=0, in_ready=1, slots=0.
- Wrap: send 0xFFFFFFFF x5 -> all ops=0xFFFFFFFF; chk_sum=0xFFFFFFFB.
- Flush: send 7,8,9, then flush=1 with in_valid=1 data 0xA -> fill_cnt=0, slots=0, word 0xA discarded. Then 1..5 -> op_a=1..op_e=5.
- Async reset: assert rst_n=0 mid-clock while in HOLD -> ops_valid, op_a..op_e, fill_cnt drop to 0 immediately without a clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel collector of five WIDTH-bit operands for the 5-input adder tree.
// Optional running checksum of accepted words: define ADDER_TREE_LOADER_CHKSUM_EN.
module adder_tree_operand_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic [WIDTH-1:0] op_e,
    output logic             ops_valid,
    input  logic             ops_ready,
    output logic [2:0]       fill_cnt,
    output logic [WIDTH-1:0] chk_sum
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_r;
    logic [2:0]       fill_cnt_r;
    logic [WIDTH-1:0] slot_r [5];
    logic             ops_valid_r;

    // Set assembly, hand-off and flush state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            fill_cnt_r  <= 3'd0;
            ops_valid_r <= 1'b0;
            for (int i = 0; i < 5; i++) slot_r[i] <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r     <= ST_FILL;
            fill_cnt_r  <= 3'd0;
            ops_valid_r <= 1'b0;
            for (int i = 0; i < 5; i++) slot_r[i] <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_valid) begin
                        // Slots above the final word are zero-filled when the set ends early
                        for (int i = 0; i < 5; i++) begin
                            if (3'(i) == fill_cnt_r) begin
                                slot_r[i] <= in_data;
                            end else if (in_last && (3'(i) > fill_cnt_r)) begin
                                slot_r[i] <= {WIDTH{1'b0}};
                            end else begin
                                slot_r[i] <= slot_r[i];
                            end
                        end
                        if (in_last || (fill_cnt_r == 3'd4)) begin
                            state_r     <= ST_HOLD;
                            fill_cnt_r  <= 3'd5;
                            ops_valid_r <= 1'b1;
                        end else begin
                            fill_cnt_r  <= fill_cnt_r + 3'd1;
                        end
                    end else begin
                        fill_cnt_r <= fill_cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (ops_ready) begin
                        state_r     <= ST_FILL;
                        fill_cnt_r  <= 3'd0;
                        ops_valid_r <= 1'b0;
                        for (int i = 0; i < 5; i++) slot_r[i] <= {WIDTH{1'b0}};
                    end else begin
                        ops_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_FILL;
                    fill_cnt_r  <= 3'd0;
                    ops_valid_r <= 1'b0;
                    for (int i = 0; i < 5; i++) slot_r[i] <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_FILL);
    assign ops_valid = ops_valid_r;
    assign fill_cnt  = fill_cnt_r;
    assign op_a      = slot_r[0];
    assign op_b      = slot_r[1];
    assign op_c      = slot_r[2];
    assign op_d      = slot_r[3];
    assign op_e      = slot_r[4];

`ifdef ADDER_TREE_LOADER_CHKSUM_EN
    logic [WIDTH-1:0] chk_sum_r;

    // Running modulo-2^WIDTH sum of accepted words, cleared with the set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sum_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            chk_sum_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_FILL) && in_valid) begin
            chk_sum_r <= chk_sum_r + in_data;
        end else if ((state_r == ST_HOLD) && ops_ready) begin
            chk_sum_r <= {WIDTH{1'b0}};
        end else begin
            chk_sum_r <= chk_sum_r;
        end
    end

    assign chk_sum = chk_sum_r;
`else
    assign chk_sum = {WIDTH{1'b0}};
`endif

endmodule
